// File: rtl/comparator_pkg.sv
// Shared definitions for the 2-bit magnitude comparator.
//   OPERAND_WIDTH : width of each compared operand
//   operand_t     : one operand
//   cmpResult_t   : one-hot compare result, bit order {gt, eq, lt}
//   CMP_GT/EQ/LT  : the three legal result encodings
//   CMP_NONE      : all-zero value held while in reset

package comparator_pkg;

  localparam int OPERAND_WIDTH = 2;

  typedef logic [OPERAND_WIDTH-1:0] operand_t;
  typedef logic [2:0]               cmpResult_t;

  localparam cmpResult_t CMP_GT   = 3'b100;
  localparam cmpResult_t CMP_EQ   = 3'b010;
  localparam cmpResult_t CMP_LT   = 3'b001;
  localparam cmpResult_t CMP_NONE = 3'b000;

endpackage

// File: rtl/comparator_2bit_if.sv
// Operand/result bundle for comparator_2bit.
//   a1,a2     : operand A, A = {a1,a2}
//   b1,b2     : operand B, B = {b1,b2}
//   in_valid  : operands valid this cycle
//   AgB/AeB/AlB : registered A>B / A==B / A<B flags
//   out_valid : one-cycle strobe marking a fresh result
// master drives operands and reads results; slave is the comparator.

interface comparator_2bit_if;

  logic a1;
  logic a2;
  logic b1;
  logic b2;
  logic in_valid;
  logic AgB;
  logic AeB;
  logic AlB;
  logic out_valid;

  modport master (
    output a1, a2, b1, b2, in_valid,
    input  AgB, AeB, AlB, out_valid
  );

  modport slave (
    input  a1, a2, b1, b2, in_valid,
    output AgB, AeB, AlB, out_valid
  );

endinterface

// File: rtl/comparator_2bit_core.sv
// Purely combinational unsigned 2-bit magnitude compare.
//   opA, opB : operands
//   result   : one-hot {gt, eq, lt}

module comparator_2bit_core
  import comparator_pkg::*;
(
  input  operand_t   opA,
  input  operand_t   opB,
  output cmpResult_t result
);

  always_comb begin
    result = CMP_EQ;
    if (opA > opB) begin
      result = CMP_GT;
    end else if (opA < opB) begin
      result = CMP_LT;
    end
  end

endmodule

// File: rtl/comparator_2bit.sv
// Registered 2-bit comparator top.
//   clk   : single clock, rising edge
//   rst   : synchronous active-high reset
//   cmpIf : operand/result bundle (slave side)
// A result is captured only when in_valid is high; otherwise the flags
// hold and out_valid drops. After reset the flags are all zero, so
// consumers must qualify them with out_valid.

module comparator_2bit
  import comparator_pkg::*;
(
  input logic              clk,
  input logic              rst,
  comparator_2bit_if.slave cmpIf
);

  operand_t   opA;
  operand_t   opB;
  cmpResult_t coreResult;
  cmpResult_t resultQ;
  logic       outValidQ;

  assign opA = {cmpIf.a1, cmpIf.a2};
  assign opB = {cmpIf.b1, cmpIf.b2};

  comparator_2bit_core uCore (
    .opA    (opA),
    .opB    (opB),
    .result (coreResult)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resultQ   <= CMP_NONE;
      outValidQ <= 1'b0;
    end else begin
      outValidQ <= cmpIf.in_valid;
      if (cmpIf.in_valid) begin
        resultQ <= coreResult;
      end
    end
  end

  assign cmpIf.AgB       = resultQ[2];
  assign cmpIf.AeB       = resultQ[1];
  assign cmpIf.AlB       = resultQ[0];
  assign cmpIf.out_valid = outValidQ;

endmodule

// File: tb/tb_comparator_2bit.sv
// Directed self-checking bench for comparator_2bit.

module tb_comparator_2bit;

  logic clk;
  logic rst;
  int   numCompared;
  int   numMismatched;

  comparator_2bit_if cmpIf ();

  comparator_2bit dut (
    .clk   (clk),
    .rst   (rst),
    .cmpIf (cmpIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected {gt,eq,lt} for i = {a1,a2,b1,b2}, A = i[3:2], B = i[1:0]
  logic [2:0] sweepExp [16] = '{
    3'b010, 3'b001, 3'b001, 3'b001,
    3'b100, 3'b010, 3'b001, 3'b001,
    3'b100, 3'b100, 3'b010, 3'b001,
    3'b100, 3'b100, 3'b100, 3'b010
  };

  task automatic driveOps(input logic [1:0] a, input logic [1:0] b, input logic v);
    cmpIf.a1       = a[1];
    cmpIf.a2       = a[0];
    cmpIf.b1       = b[1];
    cmpIf.b2       = b[0];
    cmpIf.in_valid = v;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    driveOps(2'd3, 2'd0, 1'b1);
    stepCycle();
    stepCycle();
    numCompared++;
    if ({cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid} !== 4'b0000) begin
      numMismatched++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid});
    end
    rst = 1'b0;
    driveOps(2'd0, 2'd0, 1'b0);
    stepCycle();
    numCompared++;
    if ({cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid} !== 4'b0000) begin
      numMismatched++;
      $display("FAIL reset_idle: got %b expected 0000",
               {cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid});
    end
  endtask

  task automatic test_sweep();
    int gtCount = 0;
    int eqCount = 0;
    int ltCount = 0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] vec;
      vec = 4'(i);
      driveOps(vec[3:2], vec[1:0], 1'b1);
      stepCycle();
      numCompared++;
      if ({cmpIf.AgB, cmpIf.AeB, cmpIf.AlB} !== sweepExp[i] || cmpIf.out_valid !== 1'b1) begin
        numMismatched++;
        $display("FAIL sweep_%0d: got flags %b valid %b expected flags %b valid 1",
                 i, {cmpIf.AgB, cmpIf.AeB, cmpIf.AlB}, cmpIf.out_valid, sweepExp[i]);
      end
      numCompared++;
      if (32'(cmpIf.AgB) + 32'(cmpIf.AeB) + 32'(cmpIf.AlB) != 1) begin
        numMismatched++;
        $display("FAIL onehot_%0d: got %b expected exactly one bit set",
                 i, {cmpIf.AgB, cmpIf.AeB, cmpIf.AlB});
      end
      gtCount += int'(cmpIf.AgB);
      eqCount += int'(cmpIf.AeB);
      ltCount += int'(cmpIf.AlB);
    end
    numCompared++;
    if (gtCount != 6 || eqCount != 4 || ltCount != 6) begin
      numMismatched++;
      $display("FAIL sweep_totals: got gt=%0d eq=%0d lt=%0d expected gt=6 eq=4 lt=6",
               gtCount, eqCount, ltCount);
    end
  endtask

  task automatic test_hold();
    driveOps(2'd3, 2'd1, 1'b1);
    stepCycle();
    numCompared++;
    if ({cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid} !== 4'b1001) begin
      numMismatched++;
      $display("FAIL hold_load: got %b expected 1001",
               {cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid});
    end
    driveOps(2'd0, 2'd3, 1'b0);
    for (int k = 0; k < 2; k++) begin
      stepCycle();
      numCompared++;
      if ({cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid} !== 4'b1000) begin
        numMismatched++;
        $display("FAIL hold_cycle%0d: got %b expected 1000",
                 k, {cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid});
      end
    end
  endtask

  task automatic test_back_to_back();
    // valid, bubble, valid, valid: out_valid must track in_valid one cycle later
    logic [1:0] aSeq [4] = '{2'd1, 2'd3, 2'd0, 2'd2};
    logic [1:0] bSeq [4] = '{2'd2, 2'd3, 2'd0, 2'd3};
    logic       vSeq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] expSeq [4] = '{4'b0011, 4'b0010, 4'b0101, 4'b0011};
    for (int k = 0; k < 4; k++) begin
      driveOps(aSeq[k], bSeq[k], vSeq[k]);
      stepCycle();
      numCompared++;
      if ({cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid} !== expSeq[k]) begin
        numMismatched++;
        $display("FAIL b2b_%0d: got %b expected %b",
                 k, {cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid}, expSeq[k]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    driveOps(2'd1, 2'd0, 1'b1);
    stepCycle();
    rst = 1'b1;
    driveOps(2'd0, 2'd3, 1'b1);
    stepCycle();
    numCompared++;
    if ({cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid} !== 4'b0000) begin
      numMismatched++;
      $display("FAIL midrst_clear: got %b expected 0000",
               {cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid});
    end
    rst = 1'b0;
    driveOps(2'd2, 2'd2, 1'b1);
    stepCycle();
    numCompared++;
    if ({cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid} !== 4'b0101) begin
      numMismatched++;
      $display("FAIL midrst_first: got %b expected 0101",
               {cmpIf.AgB, cmpIf.AeB, cmpIf.AlB, cmpIf.out_valid});
    end
    driveOps(2'd0, 2'd0, 1'b0);
    stepCycle();
  endtask

  initial begin
    numCompared   = 0;
    numMismatched = 0;
    rst = 1'b1;
    driveOps(2'd0, 2'd0, 1'b0);
    test_reset();
    test_sweep();
    test_hold();
    test_back_to_back();
    test_reset();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/comparator_2bit.md
COMPARATOR_2BIT -- requirements
Module: comparator_2bit

Interface
Parameters: none; all widths are fixed.
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-003 a1  input  1  MSB of operand A.
REQ-004 a2  input  1  LSB of operand A; A = {a1,a2}, unsigned 0..3.
REQ-005 b1  input  1  MSB of operand B.
REQ-006 b2  input  1  LSB of operand B; B = {b1,b2}, unsigned 0..3.
REQ-007 in_valid  input  1  operands valid this cycle; compare is captured only when high.
REQ-008 AgB  output  1  registered flag, A > B.
REQ-009 AeB  output  1  registered flag, A == B.
REQ-010 AlB  output  1  registered flag, A < B.
REQ-011 out_valid  output  1  high for one cycle when AgB/AeB/AlB carry a new result.

Function
REQ-012 Comparison SHALL be unsigned 2-bit magnitude compare of {a1,a2} against {b1,b2}.
REQ-013 On a rising edge with rst=0 and in_valid=1, AgB/AeB/AlB SHALL load the compare result of the operands present that cycle.
- Latency: exactly 1 cycle.
REQ-014 On that same edge, out_valid SHALL be set to 1.
REQ-015 On a rising edge with rst=0 and in_valid=0:
- out_valid SHALL be cleared to 0.
- AgB/AeB/AlB SHALL hold their previous values.
REQ-016 After at least one accepted compare, exactly one of AgB, AeB, AlB SHALL be 1 (one-hot).
REQ-017 Back-to-back in_valid cycles SHALL each produce a result on the following cycle, with no bubbles. Throughput is one compare per clock.
REQ-018 Operand changes while in_valid=0 SHALL have no effect on outputs.
REQ-019 Outputs SHALL be driven only from flops; there is no combinational path from inputs to outputs.

Reset
REQ-020 While rst=1 at a rising edge, AgB, AeB, AlB and out_valid SHALL all be 0, regardless of in_valid.
REQ-021 In the all-zero post-reset state, outputs are not one-hot; consumers SHALL qualify the flags with out_valid.
REQ-022 If rst is asserted mid-stream, it SHALL discard the compare captured in that cycle. The first result after rst deasserts SHALL appear one cycle after the first in_valid=1 edge.

Structure
REQ-023 A shared package comparator_pkg SHALL hold:
- the operand width constant (2);
- a 3-bit result type ordered {gt,eq,lt}, with named constants CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001.
REQ-024 A single purely combinational sub-module comparator_2bit_core SHALL:
- take the two 2-bit operands;
- return the 3-bit one-hot {gt,eq,lt} result.
The top SHALL register this result and out_valid.

Verification
REQ-025 Exhaustive sweep: apply all 16 values of {a1,a2,b1,b2}=0..15 with in_valid=1, one per cycle. Each result SHALL appear one cycle later.
- Example: i=6 (A=1,B=2) -> AlB=1.
- Example: i=9 (A=2,B=1) -> AgB=1.
- Example: i=5, 10, 15 -> AeB=1.
- Totals: 6 gt, 4 eq, 6 lt; out_valid=1 throughout.
REQ-026 Reset check: assert rst with in_valid=1 and A=3, B=0 -> next cycle AgB=AeB=AlB=out_valid=0.
REQ-027 Hold check: compare A=3, B=1 (AgB=1), then in_valid=0 with A=0, B=3.
- Flags SHALL stay AgB=1.
- out_valid SHALL drop to 0.
REQ-028 Mid-stream reset: in_valid=1 with A=0, B=3 on the same edge as rst=1 -> outputs 0. Release rst and apply A=2, B=2 -> AeB=1 one cycle later.
REQ-029 One-hot assertion: whenever out_valid=1, AgB+AeB+AlB SHALL equal 1.
